// File: rtl/pkg_balanca.sv
// Shared constants for the scale display path (weight and price displays).
package pkg_balanca;

    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] SCAN  = 1'b1;

    localparam logic [3:0] ANODO_OFF  = 4'b1111;
    localparam logic [3:0] DIGIT_ERRO = 4'hF;

    localparam int REFRESH_DIV_DEF = 50000;

    // True when any nibble of the word is not a decimal digit
    function automatic logic bcd_invalido(input logic [15:0] w);
        logic inv;
        inv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w[i*4 +: 4] > 4'd9) inv = 1'b1;
        end
        return inv;
    endfunction

endpackage

// File: rtl/seletor_digito_bcd.sv
// Picks one BCD nibble out of a 4-digit word; idx 3 is the leftmost digit.
module seletor_digito_bcd
    import pkg_balanca::*;
(
    input  logic [15:0] palavra,
    input  logic [1:0]  idx,
    output logic [3:0]  nibble,
    output logic        digito_inteiro
);

    always_comb begin
        nibble = 4'd0;
        unique case (idx)
            2'd3: nibble = palavra[15:12];
            2'd2: nibble = palavra[11:8];
            2'd1: nibble = palavra[7:4];
            2'd0: nibble = palavra[3:0];
            default: nibble = 4'd0;
        endcase
    end

    assign digito_inteiro = (idx == 2'd3);

endmodule

// File: rtl/controlador_varredura_peso.sv
// Multiplexed 7-segment scan of the X.XXX kg weight with tear-free frame commits.
// Optional invalid-BCD detection is enabled by defining BCD_CHECK_EN.
module controlador_varredura_peso
    import pkg_balanca::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEF,
    parameter int CNT_W       = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_total,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [3:0]  digit_bcd,
    output logic [3:0]  anodo,
    output logic        dp,
    output logic        frame_done,
    output logic        erro
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      stage_q, stage_d;
    logic [15:0]      disp_q, disp_d;
    logic             pending_q, pending_d;
    logic             ready_q, ready_d;
    logic             erro_q, erro_d;
    logic             frame_done_q, frame_done_d;
    logic [3:0]       anodo_q, anodo_d;
    logic [3:0]       digit_q, digit_d;
    logic             dp_q, dp_d;

    logic             xfer;
    logic             wrap;
    logic             load_disp;
    logic [3:0]       sel_nibble;
    logic             sel_int;

    seletor_digito_bcd u_sel (
        .palavra        (disp_q),
        .idx            (idx_q),
        .nibble         (sel_nibble),
        .digito_inteiro (sel_int)
    );

    assign xfer = load_valid && ready_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        stage_d      = stage_q;
        disp_d       = disp_q;
        pending_d    = pending_q;
        erro_d       = erro_q;
        frame_done_d = 1'b0;
        anodo_d      = ANODO_OFF;
        digit_d      = 4'd0;
        dp_d         = 1'b1;
        wrap         = 1'b0;
        load_disp    = 1'b0;

        unique case (state_q)
            BLANK: begin
                // First value bypasses staging: nothing is on screen to tear
                if (xfer) begin
                    disp_d    = bcd_total;
                    load_disp = 1'b1;
                    state_d   = SCAN;
                    cnt_d     = '0;
                    idx_d     = 2'd3;
                end
            end
            SCAN: begin
                anodo_d = ~(4'b0001 << idx_q);
                digit_d = erro_q ? DIGIT_ERRO : sel_nibble;
                dp_d    = !(sel_int && !erro_q);
                if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                    cnt_d = '0;
                    idx_d = idx_q - 2'd1;
                    wrap  = (idx_q == 2'd0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (wrap) begin
                    frame_done_d = 1'b1;
                    if (pending_q) begin
                        disp_d    = stage_q;
                        pending_d = 1'b0;
                        load_disp = 1'b1;
                    end
                end
                if (xfer) begin
                    stage_d   = bcd_total;
                    pending_d = 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase

        ready_d = !pending_d;

`ifdef BCD_CHECK_EN
        if (load_disp) erro_d = bcd_invalido(disp_d);
`else
        erro_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= 2'd3;
            stage_q      <= '0;
            disp_q       <= '0;
            pending_q    <= 1'b0;
            ready_q      <= 1'b1;
            erro_q       <= 1'b0;
            frame_done_q <= 1'b0;
            anodo_q      <= ANODO_OFF;
            digit_q      <= 4'd0;
            dp_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            stage_q      <= stage_d;
            disp_q       <= disp_d;
            pending_q    <= pending_d;
            ready_q      <= ready_d;
            erro_q       <= erro_d;
            frame_done_q <= frame_done_d;
            anodo_q      <= anodo_d;
            digit_q      <= digit_d;
            dp_q         <= dp_d;
        end
    end

    assign load_ready = ready_q;
    assign digit_bcd  = digit_q;
    assign anodo      = anodo_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
    assign erro       = erro_q;

endmodule

// File: tb/tb_controlador_varredura_peso.sv
// Randomised and directed bench for the weight display scanner, REFRESH_DIV=4.
module tb_controlador_varredura_peso;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bcd_total;
    logic        load_valid;
    logic        load_ready;
    logic [3:0]  digit_bcd;
    logic [3:0]  anodo;
    logic        dp;
    logic        frame_done;
    logic        erro;

    controlador_varredura_peso #(.REFRESH_DIV(R), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_total  (bcd_total),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .digit_bcd  (digit_bcd),
        .anodo      (anodo),
        .dp         (dp),
        .frame_done (frame_done),
        .erro       (erro)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: elapsed-time view of the scan
    bit        m_scan;
    int        m_k;
    logic [15:0] m_disp, m_stage;
    bit        m_pend, m_err;
    logic [3:0] e_anodo, e_digit;
    logic       e_dp, e_fd;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit invalid_bcd(input logic [15:0] w);
`ifdef BCD_CHECK_EN
        for (int i = 0; i < 4; i++)
            if (((w >> (4*i)) & 16'hF) > 9) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_scan = 0; m_k = 0; m_disp = 0; m_stage = 0;
        m_pend = 0; m_err = 0;
        e_anodo = 4'b1111; e_digit = 0; e_dp = 1; e_fd = 0;
    endtask

    task automatic model_edge(input bit v, input logic [15:0] w);
        bit old_pend;
        int j;
        old_pend = m_pend;
        e_anodo = 4'b1111; e_digit = 0; e_dp = 1; e_fd = 0;
        if (m_scan) begin
            j = 3 - ((m_k / R) % 4);
            e_anodo = ~(4'b0001 << j);
            e_digit = m_err ? 4'hF : 4'((m_disp >> (4*j)) & 16'hF);
            e_dp    = (j == 3 && !m_err) ? 1'b0 : 1'b1;
            m_k++;
            e_fd = (m_k % (4*R)) == 0;
            if (e_fd && m_pend) begin
                m_disp = m_stage;
                m_pend = 0;
                m_err  = invalid_bcd(m_disp);
            end
            if (v && !old_pend) begin
                m_stage = w;
                m_pend  = 1;
            end
        end else if (v && !old_pend) begin
            m_disp = w;
            m_err  = invalid_bcd(w);
            m_scan = 1;
            m_k    = 0;
        end
    endtask

    task automatic cycle(input bit v, input logic [15:0] w, input bit r);
        load_valid = v;
        bcd_total  = w;
        rst_n      = r;
        @(posedge clk);
        if (!r) model_reset();
        else model_edge(v, w);
        #1;
        chk("anodo", 16'(anodo), 16'(e_anodo));
        chk("digit_bcd", 16'(digit_bcd), 16'(e_digit));
        chk("dp", 16'(dp), 16'(e_dp));
        chk("frame_done", 16'(frame_done), 16'(e_fd));
        chk("load_ready", 16'(load_ready), 16'(!m_pend));
        chk("erro", 16'(erro), 16'(m_err));
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] w;
        for (int i = 0; i < 4; i++) w[i*4 +: 4] = 4'($urandom_range(0, 9));
        return w;
    endfunction

    initial begin
        model_reset();
        load_valid = 0; bcd_total = 0; rst_n = 0;
        repeat (3) cycle(0, 16'h0, 0);
        repeat (100) cycle(0, 16'h0, 1);
        // first value straight from blank
        cycle(1, 16'h1234, 1);
        repeat (37) cycle(0, 16'h0, 1);
        // mid-frame staged load
        cycle(1, 16'h0500, 1);
        repeat (30) cycle(0, 16'h0, 1);
        cycle(1, 16'h0777, 1);
        // back-pressure with a held request
        repeat (60) cycle(1, 16'h9999, 1);
        repeat (5) cycle(0, 16'h0, 1);
        // reset while a value is pending
        cycle(1, 16'h0321, 1);
        repeat (3) cycle(0, 16'h0, 1);
        cycle(0, 16'h0, 0);
        repeat (40) cycle(0, 16'h0, 1);
        // invalid BCD word then a clean one
        cycle(1, 16'h1A23, 1);
        repeat (20) cycle(0, 16'h0, 1);
        cycle(1, 16'h0001, 1);
        repeat (40) cycle(0, 16'h0, 1);
        for (int n = 0; n < 3000; n++) begin
            bit v, r;
            logic [15:0] w;
            v = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 499) != 0);
            w = ($urandom_range(0, 7) == 0) ? 16'($urandom) : rand_bcd();
            cycle(v, w, r);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/controlador_varredura_peso.md
Name: controlador_varredura_peso

Overview:
- Sequences the 16-bit BCD weight word (1 integer digit plus 3 fractional digits, X.XXX kg) onto the scale's 4-digit multiplexed 7-segment display.
- Accepts new weight values through a valid/ready handshake and stages them.
- Commits a staged value only at a frame boundary, so the display never tears.
- Sits between the weight/BCD conversion path and the 7-segment decoder.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz). Legal range 2..2^20.
- CNT_W, 20: width of the refresh counter. Must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- bcd_total  in  16  weight word. [15:12] is the integer digit; [11:0] are the fractional digits, most significant first.
- load_valid  in  1  bcd_total is valid this cycle.
- load_ready  out  1  staging register is free.
- digit_bcd  out  4  BCD nibble for the currently enabled digit.
- anodo  out  4  digit enables, active-low, one-cold. [3] is the leftmost (integer) digit.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse when a full 4-digit scan completes.
- erro  out  1  invalid-BCD flag. Tied 0 unless BCD_CHECK_EN is defined.

Behaviour:
- Reset (rst_n=0 at a clk edge) values:
  - State = BLANK; refresh counter = 0; scan index idx = 3.
  - Staging register and display register = 0; pending = 0.
  - anodo = 4'b1111, dp = 1, digit_bcd = 0, load_ready = 1, frame_done = 0, erro = 0.
  - Reset mid-scan aborts immediately and discards any pending value.
- Handshake:
  - A transfer occurs when load_valid && load_ready.
  - load_ready = !pending, registered.
  - A transfer sets pending = 1 and captures bcd_total into the staging register.
  - Ready drops the cycle after the transfer. There is no overwrite of a pending value (back-pressure).
- State BLANK:
  - Outputs stay at their reset values.
  - On a transfer, the value is written directly to the display register, pending stays 0, and the state goes to SCAN with counter = 0, idx = 3.
- State SCAN:
  - The counter increments every cycle.
  - At counter == REFRESH_DIV-1: counter returns to 0 and idx decrements 3→2→1→0.
  - When idx wraps 0→3: frame_done pulses for one cycle. If pending = 1, the staging register copies to the display register and pending clears.
  - A transfer in the same cycle as a commit is impossible, because ready was 0. load_ready returns to 1 the cycle after the commit.
  - The state never returns to BLANK except via reset.
- Outputs are registered and reflect idx one cycle after the idx update:
  - anodo = ~(4'b0001 << idx).
  - digit_bcd = display nibble idx.
  - dp = 0 only when idx == 3, so the point follows the integer digit.
- Width rules:
  - Counter compare uses CNT_W bits.
  - idx is 2 bits; the wrap is natural modulo-4.

Optional Feature:
- Macro: BCD_CHECK_EN.
- Defined:
  - On each display-register load, any nibble > 9 sets erro = 1 (registered, with the load). A valid load clears it.
  - While erro = 1, digit_bcd = 4'hF for all digits (decoder renders a dash) and dp = 1.
- Undefined:
  - erro is constant 0.
  - Nibbles pass through unchecked.

Decomposition:
- Shared package/header (pkg_balanca): state encodings BLANK/SCAN, ANODO_OFF = 4'b1111, DIGIT_ERRO = 4'hF, the default REFRESH_DIV.
- One sub-module: seletor_digito_bcd. It is combinational: 16-bit word plus 2-bit idx in, nibble and integer-digit flag out. It is reused by the price display.

Test Plan (sim with REFRESH_DIV=4):
- Reset check:
  - Stimulus: hold rst_n=0 for 3 cycles, then release with load_valid=0.
  - Required: anodo=1111, dp=1, load_ready=1 for 100 cycles.
- First load:
  - Stimulus: load bcd_total=16'h1234.
  - Required: next frame sequence anodo 0111/1011/1101/1110, digit_bcd 1/2/3/4, each for 4 cycles; dp=0 only with anodo=0111.
  - Required: frame_done pulses every 16 cycles.
- Mid-frame load:
  - Stimulus: mid-frame, load 16'h0500.
  - Required: load_ready=0 next cycle; display stays 1234 until the wrap; at frame_done, 0500 is committed and load_ready=1 the following cycle.
- Back-pressure:
  - Stimulus: hold load_valid=1 with 16'h9999 while pending.
  - Required: no transfer until ready; 9999 is displayed exactly one frame after acceptance.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 mid-scan with a value pending.
  - Required: BLANK outputs on the next edge; the pending value is never displayed.
- BCD_CHECK_EN:
  - Stimulus: load 16'h1A23.
  - Required: erro=1 and digit_bcd=F on all digits; a following load of 16'h0001 clears erro at the next commit.
